// File: rtl/sensor_temperatura_reator.sv
// sensor_temperatura_reator: hysteresis/debounced overheat flag with watchdog and saturation fail-safe
module sensor_temperatura_reator #(
   parameter int TEMP_W       = 10,
   parameter int LIMITE_ALTO  = 800,
   parameter int LIMITE_BAIXO = 750,
   parameter int DEBOUNCE     = 3,
   parameter int TIMEOUT      = 1000
) (
   input  logic              CLOCK,
   input  logic              RESET_N,
   input  logic              temp_valid,
   input  logic [TEMP_W-1:0] temp,
   output logic              temp_ready,
   output logic              S,
   output logic              sensor_fault
);
   localparam int WW = $clog2(TIMEOUT);
   localparam int CW = $clog2(DEBOUNCE + 1);
   typedef enum logic [1:0] {ESPERA, AVALIA, FALHA} estado_t;
   estado_t           estado;
   logic [TEMP_W-1:0] amostra;
   logic [WW-1:0]     wd;
   logic [CW-1:0]     cnt;
   logic              classe, classe_nova, aceita, estouro, saturada;
   always_comb begin
      aceita      = temp_valid && temp_ready;
      estouro     = wd == WW'(TIMEOUT - 1);
      saturada    = &amostra;
      classe_nova = amostra >= TEMP_W'(LIMITE_ALTO) ? 1'b1 : amostra < TEMP_W'(LIMITE_BAIXO) ? 1'b0 : classe;
   end
   always_ff @(posedge CLOCK or negedge RESET_N)
      if (!RESET_N) begin
         estado       <= ESPERA;
         amostra      <= '0;
         wd           <= '0;
         cnt          <= '0;
         classe       <= 1'b0;
         S            <= 1'b0;
         sensor_fault <= 1'b0;
         temp_ready   <= 1'b1;
      end else
         case (estado)
            ESPERA:
               if (aceita) begin
                  amostra    <= temp;
                  wd         <= '0;
                  estado     <= AVALIA;
                  temp_ready <= 1'b0;
               end else if (estouro) begin
                  estado       <= FALHA;
                  wd           <= '0;
                  cnt          <= '0;
                  S            <= 1'b1;
                  sensor_fault <= 1'b1;
               end else
                  wd <= wd + 1'b1;
            AVALIA: begin
               temp_ready <= 1'b1;
               if (saturada || estouro) begin
                  estado       <= FALHA;
                  wd           <= '0;
                  cnt          <= '0;
                  S            <= 1'b1;
                  sensor_fault <= 1'b1;
               end else begin
                  estado <= ESPERA;
                  wd     <= wd + 1'b1;
                  classe <= classe_nova;
                  if (classe_nova == S)
                     cnt <= '0;
                  else if (cnt == CW'(DEBOUNCE - 1)) begin
                     S   <= ~S;
                     cnt <= '0;
                  end else
                     cnt <= cnt + 1'b1;
               end
            end
            FALHA:
               // saturated samples are swallowed so the block stays failed-safe
               if (aceita && !(&temp)) begin
                  amostra      <= temp;
                  estado       <= AVALIA;
                  temp_ready   <= 1'b0;
                  sensor_fault <= 1'b0;
               end
            default: estado <= ESPERA;
         endcase
endmodule

// File: tb/tb_sensor_temperatura_reator.sv
// tb_sensor_temperatura_reator: directed checks of classification, debounce, watchdog and saturation
module tb_sensor_temperatura_reator;
   logic       CLOCK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       temp_valid = 1'b0;
   logic [9:0] temp = '0;
   logic       temp_ready, S, sensor_fault;
   int         checks = 0, errors = 0;

   sensor_temperatura_reator dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .temp_valid(temp_valid), .temp(temp),
      .temp_ready(temp_ready), .S(S), .sensor_fault(sensor_fault)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK);
      #1;
   endtask

   task automatic send(input logic [9:0] v);
      temp = v;
      temp_valid = 1'b1;
      tick(1);
      temp_valid = 1'b0;
   endtask

   task automatic do_reset();
      temp_valid = 1'b0;
      RESET_N = 1'b0;
      tick(2);
      RESET_N = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (S !== 1'b0) begin errors++; $display("FAIL reset_S got %b exp 0", S); end
      checks++; if (sensor_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", sensor_fault); end
      checks++; if (temp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", temp_ready); end
   endtask

   task automatic test_hot_debounce();
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         send(10'd820);
         checks++; if (temp_ready !== 1'b0) begin errors++; $display("FAIL hot_ready_eval%0d got %b exp 0", i, temp_ready); end
         checks++; if (S !== 1'b0) begin errors++; $display("FAIL hot_S_accept%0d got %b exp 0", i, S); end
         tick(1);
         checks++; if (temp_ready !== 1'b1) begin errors++; $display("FAIL hot_ready_idle%0d got %b exp 1", i, temp_ready); end
         checks++; if (S !== (i == 3)) begin errors++; $display("FAIL hot_S_after%0d got %b exp %b", i, S, i == 3); end
      end
   endtask

   task automatic test_back_to_back();
      logic exp_r [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic exp_s [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      temp = 10'd820;
      temp_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         checks++; if (temp_ready !== exp_r[i]) begin errors++; $display("FAIL b2b_ready%0d got %b exp %b", i, temp_ready, exp_r[i]); end
         checks++; if (S !== exp_s[i]) begin errors++; $display("FAIL b2b_S%0d got %b exp %b", i, S, exp_s[i]); end
      end
      temp_valid = 1'b0;
   endtask

   task automatic test_cold_clears_count();
      logic [9:0] seq [5] = '{10'd820, 10'd820, 10'd700, 10'd820, 10'd820};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send(seq[i]);
         tick(1);
         checks++; if (S !== 1'b0) begin errors++; $display("FAIL clr_S%0d got %b exp 0", i, S); end
      end
      send(10'd820);
      tick(1);
      checks++; if (S !== 1'b1) begin errors++; $display("FAIL clr_count2 got %b exp 1", S); end
   endtask

   task automatic test_hysteresis();
      do_reset();
      repeat (3) begin send(10'd820); tick(1); end
      checks++; if (S !== 1'b1) begin errors++; $display("FAIL hys_set got %b exp 1", S); end
      for (int i = 0; i < 3; i++) begin
         send(10'd770);
         tick(1);
         checks++; if (S !== 1'b1) begin errors++; $display("FAIL hys_band%0d got %b exp 1", i, S); end
      end
      for (int i = 1; i <= 3; i++) begin
         send(10'd740);
         checks++; if (S !== 1'b1) begin errors++; $display("FAIL hys_cold_accept%0d got %b exp 1", i, S); end
         tick(1);
         checks++; if (S !== (i != 3)) begin errors++; $display("FAIL hys_cold%0d got %b exp %b", i, S, i != 3); end
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      send(10'd600);
      tick(999);
      checks++; if (sensor_fault !== 1'b0) begin errors++; $display("FAIL wd_early got %b exp 0", sensor_fault); end
      tick(1);
      checks++; if (sensor_fault !== 1'b1) begin errors++; $display("FAIL wd_fault got %b exp 1", sensor_fault); end
      checks++; if (S !== 1'b1) begin errors++; $display("FAIL wd_S got %b exp 1", S); end
      checks++; if (temp_ready !== 1'b1) begin errors++; $display("FAIL wd_ready got %b exp 1", temp_ready); end
      tick(5);
      checks++; if (sensor_fault !== 1'b1) begin errors++; $display("FAIL wd_hold got %b exp 1", sensor_fault); end
      send(10'd600);
      checks++; if (sensor_fault !== 1'b0) begin errors++; $display("FAIL wd_clear got %b exp 0", sensor_fault); end
      checks++; if (temp_ready !== 1'b0) begin errors++; $display("FAIL wd_eval_ready got %b exp 0", temp_ready); end
      tick(1);
      checks++; if (S !== 1'b1) begin errors++; $display("FAIL wd_S_cold1 got %b exp 1", S); end
      send(10'd600); tick(1);
      checks++; if (S !== 1'b1) begin errors++; $display("FAIL wd_S_cold2 got %b exp 1", S); end
      send(10'd600); tick(1);
      checks++; if (S !== 1'b0) begin errors++; $display("FAIL wd_S_cold3 got %b exp 0", S); end
   endtask

   task automatic test_saturation();
      do_reset();
      send(10'd1023);
      checks++; if (sensor_fault !== 1'b0) begin errors++; $display("FAIL sat_accept got %b exp 0", sensor_fault); end
      tick(1);
      checks++; if (sensor_fault !== 1'b1) begin errors++; $display("FAIL sat_fault got %b exp 1", sensor_fault); end
      checks++; if (S !== 1'b1) begin errors++; $display("FAIL sat_S got %b exp 1", S); end
      send(10'd1023);
      tick(1);
      checks++; if (sensor_fault !== 1'b1) begin errors++; $display("FAIL sat_again got %b exp 1", sensor_fault); end
      do_reset();
      send(10'd600);
      tick(999);
      send(10'd600);
      checks++; if (sensor_fault !== 1'b0) begin errors++; $display("FAIL wd_edge_fault got %b exp 0", sensor_fault); end
      checks++; if (temp_ready !== 1'b0) begin errors++; $display("FAIL wd_edge_ready got %b exp 0", temp_ready); end
      tick(3);
      checks++; if (sensor_fault !== 1'b0 || S !== 1'b0) begin errors++; $display("FAIL wd_edge_after got fault=%b S=%b exp 0 0", sensor_fault, S); end
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (3) begin send(10'd820); tick(1); end
      send(10'd600);
      #2 RESET_N = 1'b0;
      #1;
      checks++; if (S !== 1'b0) begin errors++; $display("FAIL arst_S got %b exp 0", S); end
      checks++; if (sensor_fault !== 1'b0) begin errors++; $display("FAIL arst_fault got %b exp 0", sensor_fault); end
      checks++; if (temp_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b exp 1", temp_ready); end
      tick(1);
      RESET_N = 1'b1;
      send(10'd820); tick(1);
      send(10'd820);
      #2 RESET_N = 1'b0;
      #1;
      checks++; if (temp_ready !== 1'b1) begin errors++; $display("FAIL arst2_ready got %b exp 1", temp_ready); end
      tick(1);
      RESET_N = 1'b1;
      send(10'd820); tick(1);
      checks++; if (S !== 1'b0) begin errors++; $display("FAIL arst_hot1 got %b exp 0", S); end
      send(10'd820); tick(1);
      checks++; if (S !== 1'b0) begin errors++; $display("FAIL arst_hot2 got %b exp 0", S); end
      send(10'd820); tick(1);
      checks++; if (S !== 1'b1) begin errors++; $display("FAIL arst_hot3 got %b exp 1", S); end
   endtask

   initial begin
      test_reset();
      test_hot_debounce();
      test_back_to_back();
      test_cold_clears_count();
      test_hysteresis();
      test_watchdog();
      test_saturation();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
